hazard_scoreboard: RTL and testbench

Read-after-write hazard and control-flush unit for the 16-bit five-stage pipeline. It consumes the decode stage's operand addresses (op1/op2), write-back request (enable/destination) and branch/jump indications. It tracks every in-flight register write until it has committed to the register file. It stalls decode while a source operand is still pending, and it generates the IF/ID flush after a taken branch or jump.

---
 rtl/hazard_scoreboard.sv | 132 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard and IF/ID flush control for the 16-bit five-stage pipeline.
// Tracks in-flight register writes, stalls decode on pending sources, flushes after taken control flow.
//
//   state    | meaning
//   ST_RUN   | normal issue; a taken branch/jump raises flush combinationally
//   ST_FLUSH | squash window; flush held, decode instructions discarded
module hazard_scoreboard #(
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned FLUSH_LEN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [2:0]  id_op1,
  input  logic [2:0]  id_op2,
  input  logic        id_use_op1,
  input  logic        id_use_op2,
  input  logic        id_wb_en,
  input  logic [2:0]  id_wb_dest,
  input  logic        id_branch,
  input  logic        id_jump,
  output logic        stall,
  output logic        flush,
  output logic [7:0]  pending,
  output logic [15:0] stall_count
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  localparam logic [1:0] FL_LOAD = 2'(FLUSH_LEN - 1);

  state_t                  state_q, state_d;
  logic [1:0]              fcnt_q, fcnt_d;
  logic [DEPTH-1:0]        sb_valid_q, sb_valid_d;
  logic [DEPTH-1:0][2:0]   sb_dest_q, sb_dest_d;
  logic [7:0]              pending_q, pending_d;
  logic [15:0]             scnt_q, scnt_d;

  logic squash;
  logic hit1, hit2;
  logic accept;
  logic ctrl_taken;
  logic insert;

  // Only entries already in flight are searched, so an instruction never waits on itself.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (sb_valid_q[i] && (sb_dest_q[i] == id_op1)) hit1 = 1'b1;
      if (sb_valid_q[i] && (sb_dest_q[i] == id_op2)) hit2 = 1'b1;
    end
    if (id_op1 == 3'd0) hit1 = 1'b0;
    if (id_op2 == 3'd0) hit2 = 1'b0;
  end

  assign squash     = (state_q == ST_FLUSH);
  assign stall      = !rst && id_valid && !squash &&
                      ((id_use_op1 && hit1) || (id_use_op2 && hit2));
  assign accept     = !rst && id_valid && !stall && !squash;
  assign ctrl_taken = accept && (id_branch || id_jump);
  assign insert     = accept && id_wb_en && (id_wb_dest != 3'd0);

  always_comb begin
    sb_valid_d    = '0;
    sb_dest_d     = '0;
    sb_valid_d[0] = insert;
    sb_dest_d[0]  = insert ? id_wb_dest : 3'd0;
    for (int i = 1; i < int'(DEPTH); i++) begin
      sb_valid_d[i] = sb_valid_q[i-1];
      sb_dest_d[i]  = sb_dest_q[i-1];
    end
  end

  always_comb begin
    pending_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (sb_valid_d[i]) pending_d[sb_dest_d[i]] = 1'b1;
    end
  end

  always_comb begin
    scnt_d = scnt_q;
    if (stall && (scnt_q != 16'hFFFF)) scnt_d = scnt_q + 16'd1;
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    flush   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (ctrl_taken) begin
          flush = 1'b1;
          if (FL_LOAD != 2'd0) begin
            state_d = ST_FLUSH;
            fcnt_d  = FL_LOAD;
          end
        end
      end
      ST_FLUSH: begin
        flush  = 1'b1;
        fcnt_d = fcnt_q - 2'd1;
        if (fcnt_q == 2'd1) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (rst) flush = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fcnt_q     <= 2'd0;
      sb_valid_q <= '0;
      sb_dest_q  <= '0;
      pending_q  <= '0;
      scnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      sb_valid_q <= sb_valid_d;
      sb_dest_q  <= sb_dest_d;
      pending_q  <= pending_d;
      scnt_q     <= scnt_d;
    end
  end

  assign pending     = pending_q;
  assign stall_count = scnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: cycle-arithmetic reference model feeds an expectation queue,
// a negedge monitor compares; a second deep instance exercises stall_count saturation.
module tb_hazard_scoreboard;

  localparam int DEPTH     = 3;
  localparam int FL        = 2;
  localparam int SAT_DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, id_use_op1, id_use_op2, id_wb_en, id_branch, id_jump;
  logic [2:0]  id_op1, id_op2, id_wb_dest;
  logic        stall, flush;
  logic [7:0]  pending;
  logic [15:0] stall_count;

  logic        s_rst, s_valid, s_use1, s_use2, s_wb, s_br, s_jp;
  logic [2:0]  s_op1, s_op2, s_dest;
  logic        s_stall, s_flush;
  logic [7:0]  s_pending;
  logic [15:0] s_scnt;

  hazard_scoreboard #(.DEPTH(DEPTH), .FLUSH_LEN(FL)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op1(id_op1), .id_op2(id_op2),
    .id_use_op1(id_use_op1), .id_use_op2(id_use_op2), .id_wb_en(id_wb_en),
    .id_wb_dest(id_wb_dest), .id_branch(id_branch), .id_jump(id_jump),
    .stall(stall), .flush(flush), .pending(pending), .stall_count(stall_count));

  hazard_scoreboard #(.DEPTH(SAT_DEPTH), .FLUSH_LEN(1)) u_sat (
    .clk(clk), .rst(s_rst), .id_valid(s_valid), .id_op1(s_op1), .id_op2(s_op2),
    .id_use_op1(s_use1), .id_use_op2(s_use2), .id_wb_en(s_wb),
    .id_wb_dest(s_dest), .id_branch(s_br), .id_jump(s_jp),
    .stall(s_stall), .flush(s_flush), .pending(s_pending), .stall_count(s_scnt));

  typedef struct {
    logic        v;
    logic [2:0]  o1, o2, d;
    logic        u1, u2, wb, br, jp;
  } instr_t;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [7:0]  pend;
    logic [15:0] scnt;
    bit          known;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   sat_done = 0;

  // reference model state: cycle numbers, not pipeline slots
  int   cyc = 0;
  int   last_iss[8];
  int   sq_until = -1;
  int   scnt_m = 0;
  bit   known = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit mhit(input logic [2:0] r);
    int age;
    age = cyc - last_iss[r];
    return (r != 3'd0) && (age >= 1) && (age <= DEPTH);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) last_iss[r] = -1000;
    sq_until = -1;
    scnt_m   = 0;
    known    = 1;
  endtask

  // One cycle: apply inputs, predict outputs, push expectation, advance model.
  task automatic drive(input bit r, input instr_t in, output bit stl);
    exp_t e;
    bit   sq, acc;
    @(posedge clk);
    #1;
    rst = r; id_valid = in.v; id_op1 = in.o1; id_op2 = in.o2;
    id_use_op1 = in.u1; id_use_op2 = in.u2; id_wb_en = in.wb; id_wb_dest = in.d;
    id_branch = in.br; id_jump = in.jp;
    sq  = !r && (cyc <= sq_until);
    stl = !r && in.v && !sq && ((in.u1 && mhit(in.o1)) || (in.u2 && mhit(in.o2)));
    acc = !r && in.v && !stl && !sq;
    e.stall = stl;
    e.flush = !r && ((acc && (in.br || in.jp)) || sq);
    e.pend  = '0;
    for (int k = 1; k < 8; k++) if (mhit(3'(k))) e.pend[k] = 1'b1;
    e.scnt  = 16'(scnt_m);
    e.known = known;
    exp_q.push_back(e);
    if (r) begin
      model_reset();
    end else begin
      if (stl && scnt_m < 65535) scnt_m++;
      if (acc && in.wb && in.d != 3'd0) last_iss[in.d] = cyc;
      if (acc && (in.br || in.jp)) sq_until = cyc + FL - 1;
    end
    cyc++;
  endtask

  function automatic instr_t mk(input bit v, input int o1, input bit u1, input int o2, input bit u2,
                                input bit wb, input int d, input bit br, input bit jp);
    instr_t i;
    i.v = v; i.o1 = 3'(o1); i.u1 = u1; i.o2 = 3'(o2); i.u2 = u2;
    i.wb = wb; i.d = 3'(d); i.br = br; i.jp = jp;
    return i;
  endfunction

  // Present an instruction and hold it while the model says it is stalled.
  task automatic issue(input instr_t in);
    bit stl;
    int n;
    n = 0;
    do begin
      drive(1'b0, in, stl);
      n++;
    end while (stl && n < 16);
    if (stl) begin
      errors++;
      $display("FAIL issue_bound: got stall after %0d cycles expected release", n);
    end
  endtask

  task automatic idle(input int n);
    bit stl;
    for (int k = 0; k < n; k++) drive(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), stl);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stall", 16'(stall), 16'(e.stall));
      check("flush", 16'(flush), 16'(e.flush));
      if (e.known) begin
        check("pending", 16'(pending), 16'(e.pend));
        check("stall_count", stall_count, e.scnt);
      end
    end
  end

  // Self-dependent writer held continuously: one accept then SAT_DEPTH stall cycles, repeating.
  initial begin
    s_rst = 1; s_valid = 1; s_op1 = 3'd1; s_op2 = 3'd0; s_use1 = 1; s_use2 = 0;
    s_wb = 1; s_dest = 3'd1; s_br = 0; s_jp = 0;
    repeat (2) @(posedge clk);
    #1 s_rst = 0;
    repeat (1000) @(posedge clk);
    #2 check("sat_1000", s_scnt, 16'(1000 - (1000 + SAT_DEPTH) / (SAT_DEPTH + 1)));
    repeat (64000) @(posedge clk);
    #2 check("sat_65000", s_scnt, 16'(65000 - (65000 + SAT_DEPTH) / (SAT_DEPTH + 1)));
    repeat (5000) @(posedge clk);
    #2 check("sat_70000", s_scnt, 16'hFFFF);
    check("sat_stall", 16'(s_stall), 16'd1);
    sat_done = 1;
  end

  initial begin
    bit     stl;
    instr_t ri;
    rst = 1; id_valid = 0; id_op1 = 0; id_op2 = 0; id_use_op1 = 0; id_use_op2 = 0;
    id_wb_en = 0; id_wb_dest = 0; id_branch = 0; id_jump = 0;
    for (int r = 0; r < 8; r++) last_iss[r] = -1000;

    for (int k = 0; k < 2; k++)
      drive(1'b1, mk(1, $urandom_range(0, 7), 1, $urandom_range(0, 7), 1, 1,
                     $urandom_range(0, 7), 1, 1), stl);
    idle(1);

    issue(mk(1, 0, 0, 0, 0, 1, 3, 0, 0));
    issue(mk(1, 3, 1, 0, 0, 0, 0, 0, 0));
    idle(4);

    issue(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
    issue(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    issue(mk(1, 0, 0, 0, 0, 1, 5, 0, 0));
    issue(mk(1, 0, 0, 5, 0, 0, 0, 0, 0));
    idle(4);

    issue(mk(1, 0, 0, 0, 0, 1, 2, 0, 0));
    issue(mk(1, 1, 1, 0, 0, 1, 4, 0, 0));
    issue(mk(1, 1, 1, 0, 0, 1, 6, 0, 0));
    issue(mk(1, 0, 0, 2, 1, 0, 0, 0, 0));
    idle(4);

    issue(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    issue(mk(1, 0, 0, 0, 0, 1, 7, 0, 0));
    idle(2);
    issue(mk(1, 0, 0, 0, 0, 1, 7, 0, 1));
    idle(4);

    issue(mk(1, 0, 0, 0, 0, 1, 1, 0, 0));
    issue(mk(1, 2, 1, 0, 0, 0, 0, 0, 0));
    issue(mk(1, 1, 1, 0, 0, 0, 0, 1, 0));
    idle(4);

    issue(mk(1, 3, 1, 3, 1, 1, 3, 0, 0));
    issue(mk(1, 4, 1, 0, 0, 1, 4, 0, 0));
    drive(1'b0, mk(1, 4, 1, 0, 0, 0, 0, 0, 0), stl);
    drive(1'b1, mk(1, 4, 1, 0, 0, 0, 0, 0, 0), stl);
    issue(mk(1, 4, 1, 0, 0, 0, 0, 1, 0));
    drive(1'b1, mk(1, 1, 1, 1, 1, 1, 1, 0, 0), stl);
    idle(2);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        drive(1'b1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), stl);
      end else begin
        ri = mk($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 11) == 0, $urandom_range(0, 24) == 0);
        if ($urandom_range(0, 3) == 0) ri.d = 3'($urandom_range(4, 7));
        issue(ri);
      end
    end
    idle(4);

    wait (sat_done);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
